// File: rtl/nip_window_if.sv
// Handshake bundle between the row-buffer controller, the window generator and
// the neighbourhood-processing core. master = window generator, slave = environment.
interface nip_window_if #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned K       = 3,
    parameter int unsigned IMG_W   = 16,
    parameter int unsigned IMG_H   = 16
);
    localparam int unsigned SLICE_W = K * PIXEL_W;
    localparam int unsigned WIN_W   = K * SLICE_W;
    localparam int unsigned COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Column-slice stream from the row buffer
    logic               rb_valid;
    logic               rb_ready;
    logic [SLICE_W-1:0] rb_data;

    // Window stream to the processing core
    logic               win_valid;
    logic               win_ready;
    logic [WIN_W-1:0]   win_data;
    logic [COL_W-1:0]   win_col;
    logic [ROW_W-1:0]   win_row;

    modport master (
        input  rb_valid, rb_data, win_ready,
        output rb_ready, win_valid, win_data, win_col, win_row
    );

    modport slave (
        output rb_valid, rb_data, win_ready,
        input  rb_ready, win_valid, win_data, win_col, win_row
    );
endinterface

// File: rtl/nip_window_gen.sv
// K x K window generator: assembles windows from steered column slices and
// delivers them through a 2-entry in-order output queue.
module nip_window_gen #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned IMG_W   = 16,
    parameter int unsigned IMG_H   = 16,
    parameter int unsigned K       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    nip_window_if.master  win_if
);
    localparam int unsigned SLICE_W = K * PIXEL_W;
    localparam int unsigned WIN_W   = K * SLICE_W;
    localparam int unsigned COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned HIST_N  = K - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SLICE_W-1:0] hist_q [HIST_N];
    logic [SLICE_W-1:0] hist_d [HIST_N];
    logic [WIN_W-1:0]   qdata_q [2];
    logic [WIN_W-1:0]   qdata_d [2];
    logic [COL_W-1:0]   qcol_q [2];
    logic [COL_W-1:0]   qcol_d [2];
    logic [ROW_W-1:0]   qrow_q [2];
    logic [ROW_W-1:0]   qrow_d [2];
    logic [1:0]         cnt_q, cnt_d;
    logic               rb_ready_q, rb_ready_d;
    logic               win_valid_q, win_valid_d;
    logic               done_q, done_d;

    logic [SLICE_W-1:0] cols [K];
    logic [WIN_W-1:0]   win_new;
    logic [COL_W-1:0]   col_tag;
    logic               accept;
    logic               emit;
    logic               pop;

    // Handshake qualifiers; a start pulse pre-empts both transfers
    assign accept  = (state_q == S_STREAM) && rb_ready_q && win_if.rb_valid && !start;
    assign emit    = accept && (col_q >= COL_W'(K - 1));
    assign pop     = win_valid_q && win_if.win_ready && !start;
    assign col_tag = col_q - COL_W'(K - 1);

    // Candidate window: K-1 stored columns on the left, incoming slice on the right
    always_comb begin
        for (int j = 0; j < int'(HIST_N); j++) begin
            cols[j] = hist_q[j];
        end
        cols[K-1] = win_if.rb_data;
        win_new   = '0;
        for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) begin
                win_new[(r*K + c)*PIXEL_W +: PIXEL_W] = cols[c][r*PIXEL_W +: PIXEL_W];
            end
        end
    end

    // Next-state: frame sequencing, column/row tracking, shift register and queue
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hist_d  = hist_q;
        qdata_d = qdata_q;
        qcol_d  = qcol_q;
        qrow_d  = qrow_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_STREAM, S_DRAIN: begin
                if (start) begin
                    // Restart: drop queued windows, slice on the bus is ignored
                    state_d = S_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                end else begin
                    if (accept) begin
                        for (int j = 0; j < int'(HIST_N); j++) begin
                            hist_d[j] = cols[j+1];
                        end
                        if (col_q == COL_W'(IMG_W - 1)) begin
                            col_d = '0;
                            if (row_q == ROW_W'(IMG_H - K)) begin
                                state_d = S_DRAIN;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end

                    // Slot 0 is always the queue head
                    case ({emit, pop})
                        2'b10: begin
                            if (cnt_q == 2'd0) begin
                                qdata_d[0] = win_new;
                                qcol_d[0]  = col_tag;
                                qrow_d[0]  = row_q;
                            end else begin
                                qdata_d[1] = win_new;
                                qcol_d[1]  = col_tag;
                                qrow_d[1]  = row_q;
                            end
                            cnt_d = cnt_q + 2'd1;
                        end
                        2'b01: begin
                            qdata_d[0] = qdata_q[1];
                            qcol_d[0]  = qcol_q[1];
                            qrow_d[0]  = qrow_q[1];
                            cnt_d      = cnt_q - 2'd1;
                        end
                        2'b11: begin
                            if (cnt_q == 2'd1) begin
                                qdata_d[0] = win_new;
                                qcol_d[0]  = col_tag;
                                qrow_d[0]  = row_q;
                            end else begin
                                qdata_d[0] = qdata_q[1];
                                qcol_d[0]  = qcol_q[1];
                                qrow_d[0]  = qrow_q[1];
                                qdata_d[1] = win_new;
                                qcol_d[1]  = col_tag;
                                qrow_d[1]  = row_q;
                            end
                        end
                        default: ;
                    endcase

                    if ((state_q == S_DRAIN) && (cnt_d == 2'd0)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rb_ready_d  = (state_d == S_STREAM) && (cnt_d < 2'd2);
        win_valid_d = (cnt_d != 2'd0);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            rb_ready_q  <= 1'b0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int j = 0; j < int'(HIST_N); j++) begin
                hist_q[j] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                qdata_q[i] <= '0;
                qcol_q[i]  <= '0;
                qrow_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            rb_ready_q  <= rb_ready_d;
            win_valid_q <= win_valid_d;
            done_q      <= done_d;
            hist_q      <= hist_d;
            qdata_q     <= qdata_d;
            qcol_q      <= qcol_d;
            qrow_q      <= qrow_d;
        end
    end

    assign win_if.rb_ready  = rb_ready_q;
    assign win_if.win_valid = win_valid_q;
    assign win_if.win_data  = qdata_q[0];
    assign win_if.win_col   = qcol_q[0];
    assign win_if.win_row   = qrow_q[0];
    assign done             = done_q;
endmodule

// File: tb/tb_nip_window_gen.sv
// Bench for nip_window_gen on a 6x5 image with 3x3 windows and pixel(r,c)=16r+c.
module tb_nip_window_gen;
    localparam int PW      = 8;
    localparam int IW      = 6;
    localparam int IH      = 5;
    localparam int KK      = 3;
    localparam int SW      = KK * PW;
    localparam int DW      = KK * KK * PW;
    localparam int WPR     = IW - KK + 1;
    localparam int TOTAL_W = WPR * (IH - KK + 1);
    localparam int TOTAL_S = IW * (IH - KK + 1);
    localparam int BUDGET  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done;

    nip_window_if #(.PIXEL_W(PW), .K(KK), .IMG_W(IW), .IMG_H(IH)) bus ();

    nip_window_gen #(.PIXEL_W(PW), .IMG_W(IW), .IMG_H(IH), .K(KK)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .done   (done),
        .win_if (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: slices accepted and windows delivered in the current frame
    bit active = 1'b0;
    int acc = 0;
    int popped = 0;
    int log_n = 0;
    logic [DW-1:0] log_data [TOTAL_W];
    int            log_col  [TOTAL_W];
    int            log_row  [TOTAL_W];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int r, input int c);
        return PW'(16 * r + c);
    endfunction

    // Slice i of the frame: pass i/IW, image column i%IW, top row first
    function automatic logic [SW-1:0] slice(input int i);
        logic [SW-1:0] s;
        s = '0;
        for (int r = 0; r < KK; r++) s[r*PW +: PW] = pix(i / IW + r, i % IW);
        return s;
    endfunction

    // Window number idx in raster order, taken straight from the image
    function automatic logic [DW-1:0] exp_win(input int idx);
        logic [DW-1:0] w;
        w = '0;
        for (int r = 0; r < KK; r++)
            for (int c = 0; c < KK; c++)
                w[(r*KK + c)*PW +: PW] = pix(idx / WPR + r, idx % WPR + c);
        return w;
    endfunction

    // Windows produced once n slices of the frame have been accepted
    function automatic int produced(input int n);
        int rem;
        rem = n % IW;
        return (n / IW) * WPR + ((rem > KK - 1) ? rem - (KK - 1) : 0);
    endfunction

    // Per-cycle comparison against the model, then advance it by this cycle's transfers
    always @(negedge clk) begin
        int  outst;
        bit  er, ev, ed;
        if (rst) begin
            active = 1'b0;
            acc    = 0;
            popped = 0;
        end else begin
            outst = produced(acc) - popped;
            er = active && (acc < TOTAL_S) && (outst < 2);
            ev = active && (outst > 0);
            ed = active && (acc == TOTAL_S) && (outst == 0);
            chk("rb_ready", 128'(bus.rb_ready), 128'(er));
            chk("win_valid", 128'(bus.win_valid), 128'(ev));
            chk("done", 128'(done), 128'(ed));
            if (ev && popped < TOTAL_W) begin
                chk("win_data", 128'(bus.win_data), 128'(exp_win(popped)));
                chk("win_col", 128'(bus.win_col), 128'(popped % WPR));
                chk("win_row", 128'(bus.win_row), 128'(popped / WPR));
            end
            if (start) begin
                active = 1'b1;
                acc    = 0;
                popped = 0;
                log_n  = 0;
            end else if (active) begin
                if (bus.win_ready && ev) begin
                    if (log_n < TOTAL_W) begin
                        log_data[log_n] = bus.win_data;
                        log_col[log_n]  = int'(bus.win_col);
                        log_row[log_n]  = int'(bus.win_row);
                        log_n++;
                    end
                    popped++;
                end
                if (bus.rb_valid && er) acc++;
            end
        end
    end

    // Run one frame; optional initial stall of win_ready and optional restart after N windows
    task automatic run_frame(input int vpct, input bit rnd_ready, input int stall, input int restart_at);
        int cyc;
        bit restarted, pend;
        @(posedge clk); #1;
        start = 1'b1;
        bus.rb_valid = 1'b0;
        bus.win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        restarted = 1'b0;
        pend = 1'b0;
        while (!(active && acc == TOTAL_S && popped == TOTAL_W) && cyc < BUDGET) begin
            if (pend) begin
                chk("restart_flush", 128'(bus.win_valid), 128'(0));
                pend = 1'b0;
            end
            if (stall > 0 && cyc == stall) begin
                chk("stall_rb_ready", 128'(bus.rb_ready), 128'(0));
                chk("stall_win_valid", 128'(bus.win_valid), 128'(1));
            end
            start = 1'b0;
            bus.rb_valid = ($urandom_range(99) < vpct);
            bus.rb_data = (acc < TOTAL_S) ? slice(acc) : SW'($urandom);
            if (cyc < stall) bus.win_ready = 1'b0;
            else bus.win_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
            if (restart_at >= 0 && !restarted && popped == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
                pend = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.rb_valid = 1'b0;
        if (cyc >= BUDGET) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout actual=%0d windows required=%0d", popped, TOTAL_W);
        end else begin
            chk("frame_done", 128'(done), 128'(1));
            chk("frame_windows", 128'(log_n), 128'(TOTAL_W));
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        bus.rb_valid  = 1'b0;
        bus.rb_data   = '0;
        bus.win_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rb_ready", 128'(bus.rb_ready), 128'(0));
        chk("rst_win_valid", 128'(bus.win_valid), 128'(0));
        chk("rst_win_data", 128'(bus.win_data), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b0;

        // Pin the reference model with hand-computed pixels
        w = exp_win(0);
        chk("model_first_centre", 128'(w[4*PW +: PW]), 128'(8'h11));
        w = exp_win(TOTAL_W - 1);
        chk("model_last_centre", 128'(w[4*PW +: PW]), 128'(8'h34));
        w = exp_win(WPR);
        chk("model_row1_pix00", 128'(w[0 +: PW]), 128'(8'h10));
        chk("model_produced", 128'(produced(8)), 128'(4));

        // Basic frame with win_ready held high
        run_frame(100, 1'b0, 0, -1);
        w = log_data[0];
        chk("basic_first_centre", 128'(w[4*PW +: PW]), 128'(8'h11));
        chk("basic_first_pos", 128'({log_row[0], log_col[0]}), 128'({32'd0, 32'd0}));
        w = log_data[TOTAL_W-1];
        chk("basic_last_centre", 128'(w[4*PW +: PW]), 128'(8'h34));
        chk("basic_last_pos", 128'({log_row[TOTAL_W-1], log_col[TOTAL_W-1]}), 128'({32'd2, 32'd3}));
        w = log_data[WPR];
        chk("wrap_pix00", 128'(w[0 +: PW]), 128'(8'h10));
        chk("wrap_pos", 128'({log_row[WPR], log_col[WPR]}), 128'({32'd1, 32'd0}));

        // Backpressure, random gaps with random ready, then restart after five windows
        run_frame(100, 1'b0, 20, -1);
        run_frame(50, 1'b1, 0, -1);
        run_frame(100, 1'b0, 0, 5);

        // Asynchronous reset between clock edges mid-frame
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.rb_valid = 1'b1;
        bus.win_ready = 1'b0;
        repeat (8) begin
            bus.rb_data = slice(acc);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_rb_ready", 128'(bus.rb_ready), 128'(0));
        chk("arst_win_valid", 128'(bus.win_valid), 128'(0));
        chk("arst_win_data", 128'(bus.win_data), 128'(0));
        chk("arst_win_col", 128'(bus.win_col), 128'(0));
        chk("arst_win_row", 128'(bus.win_row), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_rb_ready", 128'(bus.rb_ready), 128'(0));
        bus.rb_valid = 1'b0;

        // Recovery frame after reset
        run_frame(70, 1'b1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nip_window_gen.md
# nip_window_gen

Consumer-side block for the BRAM row-buffer pipeline. The row-buffer controller writes image rows into BRAM and reads K rows back in parallel as steered column slices. This block takes those slices, assembles K×K neighbourhood windows in a column shift register and tracks column and row position. It delivers each complete window to the neighbourhood-processing core through a 2-entry valid/ready output queue and signals completion when the last window has drained.

## Interface
- PIXEL_W, 8, pixel width in bits
- IMG_W, 16, image width in pixels (≥ K)
- IMG_H, 16, image height in pixels (≥ K)
- K, 3, window size (odd, ≥ 3)

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins (or restarts) a frame
- rb_valid  input  1  column slice present on rb_data
- rb_ready  output  1  block can accept a slice this cycle
- rb_data  input  K*PIXEL_W  K vertically aligned pixels; slice [PIXEL_W-1:0] = topmost row
- win_valid  output  1  window at queue head valid
- win_ready  input  1  downstream accepts window
- win_data  output  K*K*PIXEL_W  window, pixel (r,c) at index r*K+c, r=0 top, c=0 leftmost
- win_col  output  clog2(IMG_W)  output column index of window (0..IMG_W-K)
- win_row  output  clog2(IMG_H)  output row index of window (0..IMG_H-K)
- done  output  1  frame complete, held until start or rst

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: rb_ready=0, rb_valid ignored. start → STREAM, with col_cnt=0, row_cnt=0, queue empty.
- STREAM: a slice is accepted when rb_valid && rb_ready.
  - On acceptance, the window shift register shifts left by one column and inserts rb_data as column K-1.
  - col_cnt increments. At IMG_W-1 it wraps to 0 and row_cnt increments.
- Window emission: on an accepted slice with col_cnt ≥ K-1, the window formed from the previous K-1 columns plus the new slice is pushed into the queue, tagged win_col=col_cnt-(K-1) and win_row=row_cnt.
  - The first K-1 slices of each row pass produce no window.
  - The shift register is not cleared at row wrap; stale columns are simply never emitted.
- Frame length is (IMG_H-K+1) row passes of IMG_W slices each, giving (IMG_W-K+1)*(IMG_H-K+1) windows.
- When the last slice is accepted (col_cnt=IMG_W-1, row_cnt=IMG_H-K), the state goes to DRAIN. rb_ready=0 from the next cycle.
- DRAIN → DONE on the cycle the queue becomes empty.
- DONE: done=1, rb_ready=0, win_valid=0. start → STREAM (new frame).
- Queue: 2 entries, in-order.
  - rb_ready = (count < 2) in STREAM only; it is registered-state driven, with no combinational path from win_ready.
  - A push and a pop in the same cycle leave count unchanged.
- start in STREAM or DRAIN: synchronous restart. The queue is flushed, counters are cleared, and the state goes to STREAM; the slice presented that cycle is not accepted.
- start in DONE clears done on the next edge.

## Timing
- Reset (async): state=IDLE, rb_ready=0, win_valid=0, win_data=0, win_col=0, win_row=0, done=0, queue count=0, counters=0.
- Latency: a window-completing slice accepted at edge N gives win_valid=1 after edge N when the queue was empty; win_data, win_col and win_row are stable while win_valid && !win_ready.
- Throughput: one slice and one window per cycle when win_ready=1 continuously.
- Backpressure: with win_ready=0, at most 2 windows are queued, then rb_ready=0. rb_ready returns to 1 the cycle after a pop.
- done rises the cycle after the final window handshake.

## Test plan
- Basic frame (IMG_W=6, IMG_H=5, K=3), pixel(r,c)=16r+c, slice for pass p, column c = {pixel(p+2,c), pixel(p+1,c), pixel(p,c)}, win_ready=1 → 12 windows. First window is win_row=0, win_col=0 with centre pixel 0x11. Last window is win_row=2, win_col=3 with centre 0x34. done asserts the cycle after the 12th handshake.
- Row wrap: check that the window at win_row=1, win_col=0 contains only pass-1 columns 0..2, i.e. pixel (0,0) of the window = 0x10. No window is emitted for the first 2 slices of each pass.
- Backpressure: hold win_ready=0 during streaming → rb_ready drops after 2 queued windows, and win_data stays constant. Releasing win_ready gives in-order delivery with no loss or duplication (12 windows total).
- Random rb_valid gaps (50%) with random win_ready → same 12 windows in the same order as the basic frame.
- Restart: pulse start after the 5th window → queue is flushed and win_valid=0 next cycle. The full 12-window frame then follows from win_row=0, win_col=0.
- Async reset asserted mid-frame between clock edges → all outputs 0 immediately. After deassertion the block stays in IDLE (rb_ready=0) until start.
